// File: rtl/iterative_divider_32bit.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU (one quotient bit per cycle).
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow finish straight from IDLE.
module iterative_divider_32bit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned     CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic             a_neg, b_neg, in_div_zero, in_ovf;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_shift, rem_diff;
    logic             q_bit;

    // Operand conditioning at the accept edge.
    always_comb begin
        a_neg       = is_signed & dividend[WIDTH-1];
        b_neg       = is_signed & divisor[WIDTH-1];
        a_abs       = a_neg ? -dividend : dividend;
        b_abs       = b_neg ? -divisor : divisor;
        in_div_zero = (divisor == '0);
        in_ovf      = is_signed && (dividend == MIN_NEG) && (divisor == '1);
    end

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dsr_q};
        q_bit     = !(rem_shift < {1'b0, dsr_q});
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        div_zero_d  = div_zero_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d      = '0;
                    rem_d      = '0;
                    dvd_d      = a_abs;
                    dsr_d      = b_abs;
                    neg_quo_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = in_div_zero;
                    ovf_d      = in_ovf;
                    state_d    = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                    if (in_div_zero || in_ovf) begin
                        quotient_d  = in_div_zero ? '1 : MIN_NEG;
                        remainder_d = in_div_zero ? dividend : '0;
                        state_d     = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                rem_d = q_bit ? rem_diff : rem_shift;
                dvd_d = {dvd_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Divide-by-zero leaves |dividend| in rem, so the sign fix restores the raw dividend.
                remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                if (div_zero_q) begin
                    quotient_d = '1;
                end else if (ovf_q) begin
                    quotient_d  = MIN_NEG;
                    remainder_d = '0;
                end else begin
                    quotient_d = neg_quo_q ? -dvd_q : dvd_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            div_zero_q  <= div_zero_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_iterative_divider_32bit.sv
// Self-checking bench for iterative_divider_32bit: directed vector table, corner sequences, random ops.
module tb_iterative_divider_32bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int tests = 0;
    int fails = 0;

    iterative_divider_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RISC-V division semantics expressed directly with language arithmetic.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Caller must be at a negedge with the DUT idle; returns at the negedge after the done cycle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input int poke);
        int  cyc;
        int  busy_cnt;
        int  exp_lat;
        int  exp_busy;
        bit  got;
        bit  special;
        special  = (b == 32'd0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        exp_lat  = 34;
        exp_busy = 33;
`ifdef DIV_EARLY_OUT_EN
        if (special) begin
            exp_lat  = 1;
            exp_busy = 0;
        end
`endif
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        cyc       = 0;
        busy_cnt  = 0;
        got       = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 2) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            if (poke != 0 && cyc == poke) begin
                start     = 1'b1;
                dividend  = ~a;
                divisor   = b + 32'd3;
                is_signed = ~s;
            end
            if (busy) busy_cnt++;
            if (done) got = 1'b1;
        end
        chk({tag, ".done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
            chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
            chk({tag, ".quotient"}, quotient, exp_q);
            chk({tag, ".remainder"}, remainder, exp_r);
            @(negedge clk);
            chk({tag, ".done_pulse"}, 32'(done), 32'd0);
            chk({tag, ".q_hold"}, quotient, exp_q);
        end
        if (special) ; // latency expectations above already account for special cases
    endtask

    vec_t vecs[14];

    initial begin
        logic [31:0] ra, rb, rq, rr;
        logic        rs;
        int          sel;
        int          cyc;
        int          done_cnt;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2};
        vecs[1]  = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{32'h8000_0005,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h8000_0005};
        vecs[3]  = '{32'h8000_0005,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h8000_0005};
        vecs[4]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0};
        vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000};
        vecs[6]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0};
        vecs[7]  = '{32'd5,          32'hFFFF_FFFD,  1'b1, 32'hFFFF_FFFF,  32'd2};
        vecs[8]  = '{32'hFFFF_FFFB,  32'd3,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[9]  = '{32'd0,          32'd5,          1'b0, 32'd0,          32'd0};
        vecs[10] = '{32'd7,          32'd7,          1'b1, 32'd1,          32'd0};
        vecs[11] = '{32'h8000_0000,  32'd2,          1'b1, 32'hC000_0000,  32'd0};
        vecs[12] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'd1,          32'd0};
        vecs[13] = '{32'd0,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd0};

        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.quotient", quotient, 32'd0);
        chk("reset.remainder", remainder, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                   vecs[i].q, vecs[i].r, 0);
        end

        // A second start at cycle 5 (with new operands) must be ignored.
        run_op("ignored_start", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 5);

        // Reset in the middle of CALC aborts at once with no trailing done.
        dividend  = 32'd1000;
        divisor   = 32'd3;
        is_signed = 1'b0;
        start     = 1'b1;
        cyc       = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        chk("abort.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.quotient", quotient, 32'd0);
        chk("abort.remainder", remainder, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("abort.no_activity", 32'(done_cnt), 32'd0);
        run_op("after_abort", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 0);

        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rs  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = 32'd0;
                1: begin
                    rb = 32'hFFFF_FFFF;
                    if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000;
                end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            ref_div(ra, rb, rs, rq, rr);
            run_op($sformatf("rand%0d", i), ra, rb, rs, rq, rr, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
